// File: rtl/loco_uart_top.sv
// loco_uart_top: LOCO-I (MED + adaptive Golomb-Rice) lossless grayscale encoder with UART in/out
//   clk   : system clock, all logic on the rising edge
//   rst_n : synchronous reset, asserted high (legacy name)
//   rx    : UART 8N1 pixel input, raster order, asynchronous to clk
//   tx    : UART 8N1 packed bitstream output
module loco_uart_top #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int FIFO_DEPTH = 1024,
    parameter int QMAX       = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int FW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PRED, S_EMIT, S_UPD, S_PAD} state_t;

    logic          rx_m, rx_s, rx_p, rx_busy, rx_vld;
    logic [15:0]   rx_tmr, tx_tmr;
    logic [3:0]    rx_bit, tx_bit;
    logic [7:0]    rx_sh, pix, x_r, a_r, b_r, c_r, ae_r, pk_byte, push_byte;
    logic          pend, ld, pred, emit, upd, pad, push, bit_o, last, wr, pop, full, tx_busy;
    logic [31:0]   cw, cw_n;
    logic [5:0]    len, len_n;
    logic [15:0]   a_sum;
    logic [6:0]    n_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [2:0]    pk_cnt, k;
    logic [7:0]    bb, aa, cc, mn, mx, p, e, m, ae, q;
    logic          esc;
    logic [7:0]    row_buf [IMG_W];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] wp, rp;
    logic [FW:0]   f_cnt;
    logic [9:0]    tx_sh;
    state_t        st, nxt;

    // Receiver: start bit rechecked at mid-bit, data at bit centres, stop bit must be 1.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_m <= 1'b1; rx_s <= 1'b1; rx_p <= 1'b1;
            rx_busy <= 1'b0; rx_vld <= 1'b0; rx_tmr <= '0; rx_bit <= '0; rx_sh <= '0;
        end else begin
            rx_m <= rx; rx_s <= rx_m; rx_p <= rx_s; rx_vld <= 1'b0;
            if (!rx_busy) begin
                if (rx_p && !rx_s) begin
                    rx_busy <= 1'b1; rx_tmr <= 16'(DIV / 2 - 1); rx_bit <= '0;
                end
            end else if (rx_tmr != 0) begin
                rx_tmr <= rx_tmr - 16'd1;
            end else begin
                rx_tmr <= 16'(DIV - 1);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0 && rx_s) rx_busy <= 1'b0;
                else if (rx_bit == 4'd9) begin rx_busy <= 1'b0; rx_vld <= rx_s; end
                else if (rx_bit != 4'd0) rx_sh <= {rx_s, rx_sh[7:1]};
            end
        end
    end

    assign last = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (rst_n) st <= S_IDLE;
        else st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:  nxt = pend ? S_PRED : S_IDLE;
            S_PRED:  nxt = S_EMIT;
            S_EMIT:  nxt = (len == 6'd1) ? S_UPD : S_EMIT;
            S_UPD:   nxt = last ? S_PAD : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld   = (st == S_IDLE) && pend;
        pred = st == S_PRED;
        emit = st == S_EMIT;
        upd  = st == S_UPD;
        pad  = st == S_PAD;
        bit_o = cw[5'(len - 6'd1)];
        push = (emit && pk_cnt == 3'd7) || (pad && pk_cnt != 3'd0);
        push_byte = emit ? {pk_byte[6:0], bit_o} : pk_byte << (4'd8 - {1'b0, pk_cnt});
    end

    // Neighbour selection, MED prediction, residual mapping, Rice parameter and code word.
    always_comb begin
        bb = (row == '0) ? 8'd0 : b_r;
        aa = (col == '0) ? bb : a_r;
        cc = (row == '0 || col == '0) ? bb : c_r;
        mn = (aa < bb) ? aa : bb;
        mx = (aa < bb) ? bb : aa;
        p  = (cc >= mx) ? mn : (cc <= mn) ? mx : 8'(aa + bb - cc);
        e  = x_r - p;
        m  = {e[6:0], 1'b0} ^ {8{e[7]}};
        ae = e[7] ? 8'(8'd0 - e) : e;
        k  = 3'd7;
        for (int i = 7; i >= 0; i--) if ((16'(n_cnt) << i) >= a_sum) k = 3'(i);
        q   = m >> k;
        esc = q >= 8'(QMAX);
        cw_n = esc ? ((((32'd1 << QMAX) - 32'd1) << 8) | 32'(m))
                   : ((((32'd1 << q) - 32'd1) << (4'(k) + 4'd1)) | 32'(m & ((8'd1 << k) - 8'd1)));
        len_n = esc ? 6'(QMAX + 8) : 6'(q) + 6'(k) + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pend <= 1'b0; pix <= '0; x_r <= '0; a_r <= '0; b_r <= '0; c_r <= '0;
            cw <= '0; len <= '0; ae_r <= '0; a_sum <= 16'd4; n_cnt <= 7'd1;
            col <= '0; row <= '0; pk_byte <= '0; pk_cnt <= '0;
        end else begin
            if (rx_vld) begin pend <= 1'b1; pix <= rx_sh; end
            else if (ld) pend <= 1'b0;
            if (ld) begin x_r <= pix; b_r <= row_buf[col]; end
            if (pred) begin cw <= cw_n; len <= len_n; ae_r <= ae; end
            if (emit) begin
                len <= len - 6'd1; pk_byte <= {pk_byte[6:0], bit_o}; pk_cnt <= pk_cnt + 3'd1;
            end
            if (upd) begin
                a_r <= x_r; c_r <= b_r;
                if (n_cnt == 7'd63) begin
                    a_sum <= (a_sum + 16'(ae_r)) >> 1; n_cnt <= 7'd32;
                end else begin
                    a_sum <= a_sum + 16'(ae_r); n_cnt <= n_cnt + 7'd1;
                end
                col <= (col == CW'(IMG_W - 1)) ? '0 : col + 1'b1;
                if (col == CW'(IMG_W - 1)) row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end
            if (pad) begin pk_cnt <= '0; a_sum <= 16'd4; n_cnt <= 7'd1; end
        end
    end

    always_ff @(posedge clk) if (upd) row_buf[col] <= x_r;

    assign full = f_cnt == (FW + 1)'(FIFO_DEPTH);
    assign wr   = push && !full;
    assign pop  = !tx_busy && f_cnt != '0;

    always_ff @(posedge clk) if (wr) fifo[wp] <= push_byte;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wp <= '0; rp <= '0; f_cnt <= '0;
        end else begin
            wp <= wp + FW'(wr);
            rp <= rp + FW'(pop);
            f_cnt <= f_cnt + {{FW{1'b0}}, wr} - {{FW{1'b0}}, pop};
        end
    end

    // Transmit shifter refills with ones, so its LSB is the idle-high line.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_sh <= '1; tx_busy <= 1'b0; tx_tmr <= '0; tx_bit <= '0;
        end else if (!tx_busy) begin
            if (pop) begin
                tx_sh <= {1'b1, fifo[rp], 1'b0}; tx_busy <= 1'b1; tx_tmr <= 16'(DIV - 1); tx_bit <= '0;
            end
        end else if (tx_tmr != 0) begin
            tx_tmr <= tx_tmr - 16'd1;
        end else begin
            tx_tmr <= 16'(DIV - 1);
            tx_sh <= {1'b1, tx_sh[9:1]};
            tx_bit <= tx_bit + 4'd1;
            if (tx_bit == 4'd9) tx_busy <= 1'b0;
        end
    end

    assign tx = tx_sh[0];
endmodule

// File: tb/tb_loco_uart_top.sv
// tb_loco_uart_top: scoreboard bench for the LOCO-I UART encoder on a small fast image
module tb_loco_uart_top;
    localparam int W = 8, H = 4, DIV = 16, BIT = DIV * 10;

    logic clk = 1'b0, rst_n = 1'b1, rx = 1'b1, tx;
    int n_chk = 0, n_pass = 0, n_falls = 0;
    logic mon_en = 1'b0, ignore = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] img [H][W];
    int m_a = 4, m_n = 1, m_r = 0, m_c = 0, acc = 0, acc_n = 0;

    loco_uart_top #(.CLK_HZ(DIV), .BAUD(1), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(256), .QMAX(24)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic put_bit(input int b);
        acc = ((acc << 1) | b) & 255;
        acc_n++;
        if (acc_n == 8) begin exp_q.push_back(8'(acc)); acc_n = 0; end
    endtask

    task automatic model_reset();
        m_a = 4; m_n = 1; m_r = 0; m_c = 0; acc = 0; acc_n = 0;
    endtask

    task automatic model_pixel(input int x);
        int a, b, c, p, e, m, k, q, lo, hi;
        b = (m_r == 0) ? 0 : int'(img[m_r-1][m_c]);
        c = (m_r == 0) ? 0 : (m_c == 0) ? b : int'(img[m_r-1][m_c-1]);
        a = (m_c == 0) ? b : int'(img[m_r][m_c-1]);
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        p = (c >= hi) ? lo : (c <= lo) ? hi : a + b - c;
        e = (x - p) & 255;
        if (e > 127) e -= 256;
        m = (e >= 0) ? 2 * e : -2 * e - 1;
        k = 0;
        while (k < 7 && (m_n << k) < m_a) k++;
        q = m >> k;
        if (q < 24) begin
            repeat (q) put_bit(1);
            put_bit(0);
            for (int i = k - 1; i >= 0; i--) put_bit((m >> i) & 1);
        end else begin
            repeat (24) put_bit(1);
            for (int i = 7; i >= 0; i--) put_bit((m >> i) & 1);
        end
        m_a += (e < 0) ? -e : e;
        m_n++;
        if (m_n == 64) begin m_a >>= 1; m_n >>= 1; end
        img[m_r][m_c] = 8'(x);
        m_c++;
        if (m_c == W) begin
            m_c = 0; m_r++;
            if (m_r == H) begin
                if (acc_n > 0) exp_q.push_back(8'(acc << (8 - acc_n)));
                model_reset();
            end
        end
    endtask

    task automatic send(input int d, input logic stop = 1'b1);
        if (stop) model_pixel(d);
        rx = 1'b0; #BIT;
        for (int i = 0; i < 8; i++) begin rx = 1'((d >> i) & 1); #BIT; end
        rx = stop; #BIT;
        rx = 1'b1; #(2 * BIT);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 15000) begin @(negedge clk); t++; end
        repeat (12 * DIV) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic stp;
        wait (mon_en);
        forever begin
            @(negedge tx);
            n_falls++;
            #(BIT / 2 + 5);
            for (int i = 0; i < 8; i++) begin #BIT; b[i] = tx; end
            #BIT; stp = tx;
            if (!ignore) begin
                check("tx_stop", stp, 1);
                if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
                else check("tx_byte", b, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        repeat (300) @(negedge clk);
        check("idle_falls", n_falls, 0);
        send(0);
        repeat (60) @(negedge clk);
        check("no_early_tx", n_falls, 0);
        for (int i = 1; i < W * H; i++) send(((i / W) * 16 + (i % W) * 8 + $urandom_range(0, 3)) & 255);
        send(8'h80);
        for (int i = 1; i < W * H; i++) begin
            if (i == 5) send(8'h55, 1'b0);
            send(8'h80 + $urandom_range(0, 6) - 3);
        end
        repeat (W * H) send(0);
        repeat (W * H) send($urandom_range(0, 255));
        wait_drain();
        check("drain_mid", exp_q.size(), 0);
        repeat (10) send($urandom_range(0, 255));
        rx = 1'b0; #(3 * BIT);
        ignore = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; rx = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_tx", tx, 1);
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (12 * DIV) @(negedge clk);
        ignore = 1'b0;
        for (int i = 0; i < W * H; i++) send(((i / W) * 16 + (i % W) * 8 + $urandom_range(0, 3)) & 255);
        wait_drain();
        check("drain_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
